// File: rtl/mem_reg_bank_pkg.sv
// Shared definitions for the mem_reg_bank register target.
//   - Word indices of the fixed registers in the map.
//   - Transaction FSM state encoding.
//   - Default identification word.
package mem_reg_bank_pkg;

  localparam int IDX_ID     = 0;  // read-only identification word
  localparam int IDX_STATUS = 1;  // sticky event bits, write-one-to-clear
  localparam int IDX_IRQ_EN = 2;  // interrupt enable mask
  localparam int IDX_CTRL0  = 3;  // first general control word, drives ctrl_out

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA11C_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for wen/ren
    ST_WAIT = 2'd1,  // emulated peripheral wait states
    ST_RESP = 2'd2,  // mem_ready pulse
    ST_TURN = 2'd3   // turnaround while the requester drops its request
  } state_t;

endpackage

// File: rtl/mem_status_w1c.sv
// Sticky status register with write-one-to-clear semantics.
//   clk, rst   : clock, synchronous active-high reset
//   set        : per-bit event pulses; a set bit stays set until cleared
//   clr_en     : a bus write targets this register this cycle
//   wdata      : write data; each 1 clears the matching bit...
//   wstrb      : ...but only inside byte lanes that are enabled
//   status_q   : current register contents
//   status_d   : next-state value (used for registering irq without extra lag)
module mem_status_w1c
  import mem_reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   set,
  input  logic                    clr_en,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   status_q,
  output logic [DATA_WIDTH-1:0]   status_d
);

  logic [DATA_WIDTH-1:0] clr_mask;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    clr_mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (clr_en && wstrb[b]) begin
        clr_mask[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    // Set is OR'd in after the clear so a coincident event wins.
    status_d = (status_q & ~clr_mask) | set;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

endmodule

// File: rtl/mem_reg_bank.sv
// Register-bank target for the mem_* port of a bus slave interface.
//   clk, rst          : clock, synchronous active-high reset
//   mem_addr          : byte address, bits [1:0] ignored
//   mem_wdata/wstrb   : write data and byte enables
//   mem_wen/mem_ren   : requests, held by the requester until mem_ready
//   mem_rdata         : read data, holds last captured read value
//   mem_ready         : one-cycle completion pulse
//   evt_in            : event pulses that set STATUS bits
//   ctrl_out          : contents of CTRL0
//   irq               : registered |(STATUS & IRQ_EN)
// Map (word index from BASE_ADDR): 0 ID, 1 STATUS, 2 IRQ_EN, 3.. CTRLn.
module mem_reg_bank
  import mem_reg_bank_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(DEFAULT_ID_VALUE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_wen,
  input  logic                    mem_ren,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   evt_in,
  output logic [DATA_WIDTH-1:0]   ctrl_out,
  output logic                    irq
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  state_t state_q, state_d;
  logic [3:0] wait_cnt_q;

  // Request captured in IDLE and used for the rest of the transaction.
  logic                  hit_q, wr_q, rd_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  // RW words only; ID is a constant and STATUS lives in the sub-module.
  logic [DATA_WIDTH-1:0] rw_q [IDX_IRQ_EN:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] status_q, status_d;

  // Live decode. Working in word units keeps bits [1:0] out of the math.
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  live_hit, req;

  assign word_off = (mem_addr >> 2) - (BASE_ADDR >> 2);
  assign live_hit = (mem_addr >= BASE_ADDR) && (word_off < ADDR_WIDTH'(NUM_REGS));
  assign req      = mem_wen | mem_ren;

  // With zero wait states the commit edge is the IDLE sampling edge, so the
  // live request is used there; otherwise the latched copy.
  logic                  in_idle, op_hit, op_wr, op_rd, commit, do_write, do_read;
  logic [IDX_W-1:0]      op_idx;
  logic [DATA_WIDTH-1:0] op_wdata, rd_val;
  logic [STRB_W-1:0]     op_wstrb;

  assign in_idle  = (state_q == ST_IDLE);
  assign op_hit   = in_idle ? live_hit                : hit_q;
  assign op_wr    = in_idle ? mem_wen                 : wr_q;
  assign op_rd    = in_idle ? (mem_ren & ~mem_wen)    : rd_q;  // write wins
  assign op_idx   = in_idle ? word_off[IDX_W-1:0]     : idx_q;
  assign op_wdata = in_idle ? mem_wdata               : wdata_q;
  assign op_wstrb = in_idle ? mem_wstrb               : wstrb_q;

  assign commit   = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign do_write = commit && op_wr && op_hit;
  assign do_read  = commit && op_rd;

  // FSM next state and outputs.
  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (req) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wait_cnt_q == '0) state_d = ST_RESP;
      ST_RESP: begin
        mem_ready = 1'b1;
        state_d   = ST_TURN;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      hit_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle) begin
        // WAIT lasts WAIT_STATES cycles: it exits when the count reaches 0.
        wait_cnt_q <= 4'(WAIT_STATES - 1);
        if (req) begin
          hit_q   <= live_hit;
          wr_q    <= mem_wen;
          rd_q    <= mem_ren & ~mem_wen;
          idx_q   <= word_off[IDX_W-1:0];
          wdata_q <= mem_wdata;
          wstrb_q <= mem_wstrb;
        end
      end else if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
    end
  end

  // RW registers with byte strobes.
  always_ff @(posedge clk) begin
    // NOTE: this array is software-visible configuration, so it is reset like ordinary flops rather than left uninitialised as a RAM would be.
    if (rst) begin
      for (int r = IDX_IRQ_EN; r < NUM_REGS; r++) rw_q[r] <= '0;
    end else if (do_write) begin
      for (int r = IDX_IRQ_EN; r < NUM_REGS; r++) begin
        if (op_idx == IDX_W'(r)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (op_wstrb[b]) rw_q[r][8*b +: 8] <= op_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  mem_status_w1c #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_status (
    .clk      (clk),
    .rst      (rst),
    .set      (evt_in),
    .clr_en   (do_write && (op_idx == IDX_W'(IDX_STATUS))),
    .wdata    (op_wdata),
    .wstrb    (op_wstrb),
    .status_q (status_q),
    .status_d (status_d)
  );

  always_comb begin
    rd_val = '0;
    case (op_idx)
      IDX_W'(IDX_ID):     rd_val = ID_VALUE;
      IDX_W'(IDX_STATUS): rd_val = status_q;
      default:            rd_val = rw_q[op_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (do_read) mem_rdata <= op_hit ? rd_val : '0;
      irq <= |(status_d & rw_q[IDX_IRQ_EN]);
    end
  end

  assign ctrl_out = rw_q[IDX_CTRL0];

endmodule

// File: tb/tb_mem_reg_bank.sv
// Directed bench for mem_reg_bank: a vector table for single transactions on a
// 3-wait-state instance, hand-written sequences for STATUS/IRQ and reset
// mid-transaction, and a latency check on a zero-wait-state instance.
module tb_mem_reg_bank;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        wen3 = 1'b0, ren3 = 1'b0, wen0 = 1'b0, ren0 = 1'b0;
  logic [31:0] evt_in = '0;
  logic [31:0] evt0   = '0;

  logic [31:0] rdata3, ctrl3, rdata0, ctrl0;
  logic        ready3, irq3, ready0, irq0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_reg_bank #(.WAIT_STATES(WS)) dut3 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wen(wen3), .mem_ren(ren3),
    .mem_rdata(rdata3), .mem_ready(ready3), .evt_in(evt_in),
    .ctrl_out(ctrl3), .irq(irq3)
  );

  mem_reg_bank #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wen(wen0), .mem_ren(ren0),
    .mem_rdata(rdata0), .mem_ready(ready0), .evt_in(evt0),
    .ctrl_out(ctrl0), .irq(irq0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge with the DUT in IDLE. sel=1 targets dut0.
  task automatic xfer(input bit sel, input logic we, input logic re,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd);
    int lat = 0;
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = st;
    if (sel) begin wen0 = we; ren0 = re; end
    else     begin wen3 = we; ren3 = re; end
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (sel ? ready0 : ready3) lat = i;
    end
    rd = sel ? rdata0 : rdata3;
    {wen0, ren0, wen3, ren3} = '0;
    check("latency", 32'(lat), sel ? 32'd1 : 32'(WS + 1));
    @(negedge clk);
    check("ready_width", {31'd0, sel ? ready0 : ready3}, 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic [31:0] rd;
    bit seen;

    vecs[0]  = '{1'b1, 1'b0, 32'h100C, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         32'h1234_5678};
    vecs[1]  = '{1'b0, 1'b1, 32'h100C, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[2]  = '{1'b1, 1'b0, 32'h100C, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0,         32'h12BB_56DD};
    vecs[3]  = '{1'b0, 1'b1, 32'h100C, 32'h0,         4'h0, 1'b1, 32'h12BB_56DD, 32'h12BB_56DD};
    vecs[4]  = '{1'b0, 1'b1, 32'h1000, 32'h0,         4'h0, 1'b1, 32'hA11C_0001, 32'h12BB_56DD};
    vecs[5]  = '{1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         32'h12BB_56DD};
    vecs[6]  = '{1'b0, 1'b1, 32'h1000, 32'h0,         4'h0, 1'b1, 32'hA11C_0001, 32'h12BB_56DD};
    vecs[7]  = '{1'b0, 1'b1, 32'h2000, 32'h0,         4'h0, 1'b1, 32'h0,         32'h12BB_56DD};
    vecs[8]  = '{1'b1, 1'b0, 32'h1010, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         32'h12BB_56DD};
    vecs[9]  = '{1'b0, 1'b1, 32'h1010, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 32'h12BB_56DD};
    vecs[10] = '{1'b1, 1'b0, 32'h0FFC, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         32'h12BB_56DD};
    vecs[11] = '{1'b0, 1'b1, 32'h0FFC, 32'h0,         4'h0, 1'b1, 32'h0,         32'h12BB_56DD};
    vecs[12] = '{1'b1, 1'b0, 32'h102C, 32'h1111_1111, 4'hF, 1'b0, 32'h0,         32'h12BB_56DD};
    vecs[13] = '{1'b0, 1'b1, 32'h101C, 32'h0,         4'h0, 1'b1, 32'h0,         32'h12BB_56DD};
    vecs[14] = '{1'b0, 1'b1, 32'h1010, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 32'h12BB_56DD};
    // Both requests high: write to IRQ_EN happens, read data is not updated.
    vecs[15] = '{1'b1, 1'b1, 32'h1008, 32'h0000_0004, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h12BB_56DD};
    vecs[16] = '{1'b0, 1'b1, 32'h1008, 32'h0,         4'h0, 1'b1, 32'h0000_0004, 32'h12BB_56DD};
    vecs[17] = '{1'b0, 1'b1, 32'h100E, 32'h0,         4'h0, 1'b1, 32'h12BB_56DD, 32'h12BB_56DD};

    // Reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready",  {31'd0, ready3}, 32'd0);
    check("rst_rdata",  rdata3, 32'd0);
    check("rst_ctrl",   ctrl3,  32'd0);
    check("rst_irq",    {31'd0, irq3},   32'd0);

    // Table-driven single transactions.
    for (int i = 0; i < 18; i++) begin
      xfer(1'b0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_ctrl", i), ctrl3, vecs[i].exp_ctrl);
    end

    // STATUS/IRQ with IRQ_EN = 0x4.
    evt_in = 32'h4;
    @(negedge clk);
    evt_in = 32'h0;
    check("irq_after_evt", {31'd0, irq3}, 32'd1);
    xfer(1'b0, 1'b0, 1'b1, 32'h1004, 32'h0, 4'h0, rd);
    check("status_set", rd, 32'h4);
    xfer(1'b0, 1'b1, 1'b0, 32'h1004, 32'h4, 4'hF, rd);
    check("irq_after_clr", {31'd0, irq3}, 32'd0);
    xfer(1'b0, 1'b0, 1'b1, 32'h1004, 32'h0, 4'h0, rd);
    check("status_clr", rd, 32'h0);

    // Disabled bit: no irq; clear without byte enable has no effect.
    evt_in = 32'h20;
    @(negedge clk);
    evt_in = 32'h0;
    @(negedge clk);
    check("irq_masked", {31'd0, irq3}, 32'd0);
    xfer(1'b0, 1'b1, 1'b0, 32'h1004, 32'h20, 4'h0, rd);
    xfer(1'b0, 1'b0, 1'b1, 32'h1004, 32'h0, 4'h0, rd);
    check("status_nostrb", rd, 32'h20);
    xfer(1'b0, 1'b1, 1'b0, 32'h1004, 32'h20, 4'h1, rd);
    xfer(1'b0, 1'b0, 1'b1, 32'h1004, 32'h0, 4'h0, rd);
    check("status_strb", rd, 32'h0);

    // Event held across the clearing write: set wins.
    evt_in = 32'h4;
    xfer(1'b0, 1'b1, 1'b0, 32'h1004, 32'h4, 4'hF, rd);
    evt_in = 32'h0;
    xfer(1'b0, 1'b0, 1'b1, 32'h1004, 32'h0, 4'h0, rd);
    check("status_set_wins", rd, 32'h4);
    check("irq_set_wins", {31'd0, irq3}, 32'd1);

    // Zero-wait-state instance.
    xfer(1'b1, 1'b1, 1'b0, 32'h100C, 32'h8765_4321, 4'hF, rd);
    check("ws0_ctrl", ctrl0, 32'h8765_4321);
    xfer(1'b1, 1'b0, 1'b1, 32'h100C, 32'h0, 4'h0, rd);
    check("ws0_rdata", rd, 32'h8765_4321);

    // Reset during WAIT of a write to CTRL0.
    mem_addr  = 32'h100C;
    mem_wdata = 32'h5555_5555;
    mem_wstrb = 4'hF;
    wen3      = 1'b1;
    seen      = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ready3) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ready3) seen = 1'b1;
    end
    rst  = 1'b0;
    wen3 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready3) seen = 1'b1;
    end
    check("rst_mid_no_ready", {31'd0, seen}, 32'd0);
    check("rst_mid_ctrl", ctrl3, 32'd0);
    check("rst_mid_irq", {31'd0, irq3}, 32'd0);
    xfer(1'b0, 1'b0, 1'b1, 32'h100C, 32'h0, 4'h0, rd);
    check("rst_mid_rdata", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
